// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder with fixed-priority or round-robin resolution,
// zero/multi-hot flags and a single-register valid/ready output stage.
module prio_encoder_rr #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         zero,
    output logic         multi
);

    logic [W-1:0] ptr_r;
    logic [W-1:0] y_r;
    logic         zero_r;
    logic         multi_r;
    logic         out_valid_r;

    logic [W-1:0] fp_idx_s;
    logic [W-1:0] rr_idx_s;
    logic         rr_found_s;
    logic [W-1:0] y_next_s;
    logic         accept_s;
    logic         nonzero_s;

    // Two or more bits set iff clearing the lowest set bit leaves something.
    function automatic logic multi_hot(input logic [N-1:0] v);
        return |(v & (v - {{(N-1){1'b0}}, 1'b1}));
    endfunction

    assign in_ready  = en && !rst && (!out_valid_r || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign nonzero_s = |in;

    // Fixed priority: the last set bit seen while ascending is the highest one.
    always_comb begin
        fp_idx_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (in[i]) begin
                fp_idx_s = W'(i);
            end else begin
                fp_idx_s = fp_idx_s;
            end
        end
    end

    // Round-robin: scan from ptr+1 upwards; the W-bit add wraps modulo N.
    always_comb begin
        logic [W-1:0] cand;
        rr_idx_s   = {W{1'b0}};
        rr_found_s = 1'b0;
        cand       = {W{1'b0}};
        for (int k = 1; k <= N; k++) begin
            cand = ptr_r + W'(k);
            if (!rr_found_s && in[cand]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = cand;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Mode select; an all-zero vector always encodes to index 0.
    always_comb begin
        if (!nonzero_s) begin
            y_next_s = {W{1'b0}};
        end else if (MODE == 1) begin
            y_next_s = rr_idx_s;
        end else begin
            y_next_s = fp_idx_s;
        end
    end

    // Output register with pass-through on simultaneous pop and push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            y_r         <= {W{1'b0}};
            zero_r      <= 1'b0;
            multi_r     <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            y_r         <= y_next_s;
            zero_r      <= !nonzero_s;
            multi_r     <= multi_hot(in);
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Grant pointer; resets to N-1 so the first search begins at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= W'(N - 1);
        end else if ((MODE == 1) && accept_s && nonzero_s) begin
            ptr_r <= y_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign zero      = zero_r;
    assign multi     = multi_r;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench: four encoder instances (N=8/16 x MODE 0/1) share one
// stimulus stream and are checked against a behavioural model.
module tb_prio_encoder_rr;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_bus = 16'h0000;

    logic [ND-1:0] in_ready_v;
    logic [ND-1:0] out_valid_v;
    logic [ND-1:0] zero_v;
    logic [ND-1:0] multi_v;
    logic [3:0]    y_v [ND];

    typedef struct packed {
        logic [ND-1:0][3:0] y;
        logic [ND-1:0]      zero;
        logic [ND-1:0]      multi;
    } exp_t;

    exp_t q[$];
    int   ptr_m [ND];
    logic mvalid;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int GN = (g < 2) ? 8 : 16;
        localparam int GM = g % 2;
        logic [$clog2(GN)-1:0] yk;
        prio_encoder_rr #(.N(GN), .MODE(GM)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .in        (in_bus[GN-1:0]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .y         (yk),
            .zero      (zero_v[g]),
            .multi     (multi_v[g])
        );
        assign y_v[g] = 4'(yk);
    end

    function automatic int dut_n(input int g);
        return (g < 2) ? 8 : 16;
    endfunction

    function automatic int dut_mode(input int g);
        return g % 2;
    endfunction

    // Reference resolution straight from the rules: highest set bit, or first
    // set bit found walking upwards from the last grant with wrap-around.
    function automatic int ref_y(input logic [15:0] v, input int n, input int mode, input int p);
        if (v == 16'h0000) return 0;
        if (mode == 0) begin
            for (int i = n - 1; i >= 0; i--) if (v[i]) return i;
        end else begin
            for (int k = 1; k <= n; k++) if (v[(p + k) % n]) return (p + k) % n;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int g, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, g, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        q.delete();
        mvalid = 1'b0;
        for (int g = 0; g < ND; g++) ptr_m[g] = dut_n(g) - 1;
    endtask

    task automatic chk_reset_outputs();
        for (int g = 0; g < ND; g++) begin
            chk("rst_out_valid", g, int'(out_valid_v[g]), 0);
            chk("rst_y", g, int'(y_v[g]), 0);
            chk("rst_zero", g, int'(zero_v[g]), 0);
            chk("rst_multi", g, int'(multi_v[g]), 0);
            chk("rst_in_ready", g, int'(in_ready_v[g]), 0);
        end
    endtask

    // Async reset mid-cycle with inputs active; outputs must stay cleared across an edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        en = 1'b1; in_valid = 1'b1; in_bus = 16'hFFFF; out_ready = 1'b1;
        rst = 1'b1;
        #1;
        reset_model();
        chk_reset_outputs();
        @(posedge clk);
        #1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    // One cycle of stimulus: drive, check handshake against the model, push expectation.
    task automatic drive(input logic e, input logic iv, input logic [15:0] v, input logic ordy);
        logic mready;
        logic acc;
        exp_t ex;
        logic [15:0] vm;
        int yy;
        @(posedge clk);
        #1;
        en = e; in_valid = iv; in_bus = v; out_ready = ordy;
        #1;
        mready = e && (!mvalid || ordy);
        for (int g = 0; g < ND; g++) begin
            chk("in_ready", g, int'(in_ready_v[g]), int'(mready));
            chk("out_valid", g, int'(out_valid_v[g]), int'(mvalid));
        end
        acc = iv && mready;
        if (acc) begin
            ex = '0;
            for (int g = 0; g < ND; g++) begin
                vm = (dut_n(g) == 8) ? {8'h00, v[7:0]} : v;
                yy = ref_y(vm, dut_n(g), dut_mode(g), ptr_m[g]);
                ex.y[g]     = 4'(yy);
                ex.zero[g]  = (vm == 16'h0000);
                ex.multi[g] = ($countones(vm) >= 2);
                if (vm != 16'h0000) ptr_m[g] = yy;
            end
            q.push_back(ex);
        end
        mvalid = acc ? 1'b1 : ((mvalid && ordy) ? 1'b0 : mvalid);
    endtask

    function automatic logic [15:0] rand_vec();
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0:       return 16'h0000;
            1:       return 16'(1) << $urandom_range(0, 15);
            2:       return 16'(1) << $urandom_range(0, 7);
            3:       return 16'($urandom) & 16'h00FF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: compares each presented beat with the scoreboard head, pops on transfer.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && (out_valid_v != '0)) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 0, int'(out_valid_v), 0);
                end else begin
                    for (int g = 0; g < ND; g++) begin
                        chk("y", g, int'(y_v[g]), int'(q[0].y[g]));
                        chk("zero", g, int'(zero_v[g]), int'(q[0].zero[g]));
                        chk("multi", g, int'(multi_v[g]), int'(q[0].multi[g]));
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        reset_model();
        do_reset();
        // Walking one, back to back
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'(1) << i, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, rand_vec(), 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'(1) << i, 1'b1);
        drive(1'b1, 1'b1, 16'h0094, 1'b1);
        drive(1'b1, 1'b1, 16'h0000, 1'b1);
        // Round-robin sequence from reset
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'h0089, 1'b1);
        drive(1'b1, 1'b1, 16'h0000, 1'b1);
        drive(1'b1, 1'b1, 16'h0089, 1'b1);
        // Backpressure
        drive(1'b1, 1'b1, 16'h0026, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, rand_vec(), 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, rand_vec(), 1'b1);
        // Random with enable toggling and one mid-stream reset
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                  rand_vec(), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("drained", 0, q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered N-to-log2(N) encoder with selectable fixed-priority or round-robin resolution, zero/multi-hot flags and a valid/ready handshake on both sides. It replaces the purely combinational 8-to-3 encoder wherever the one-hot assumption cannot be guaranteed. Typical uses are request arbitration, interrupt source selection and first-set-bit lookup inside pipelined datapaths.

## Interface
- N, default 8: number of request lines; must be ≥ 2 and a power of two.
- W, default $clog2(N): width of the encoded index.
- MODE, default 0: selects how multiple set bits are resolved.
  - 0: fixed priority, highest set index wins.
  - 1: round-robin, as described under Operation.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; when low, in_ready=0 and all state holds.
- in_valid  input  1  the in vector is valid.
- in_ready  output  1  the block accepts in this cycle.
- in  input  N  request vector.
- out_valid  output  1  y, zero and multi are valid.
- out_ready  input  1  the downstream consumer takes the output.
- y  output  W  encoded winning index.
- zero  output  1  the accepted vector was all zeros.
- multi  output  1  the accepted vector had two or more bits set.

## Operation
- Transfer rules:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
- in_ready = en && (!out_valid || out_ready). The output stage is a single register with pass-through on pop and no skid buffer.
- On an input transfer, y, zero and multi are computed from in and registered; out_valid sets to 1.
- On an output transfer with no simultaneous input transfer, out_valid clears to 0; y, zero and multi hold their last values.
- Resolution in MODE 0: y is the highest set index. For example, in=8'b0010_0110 gives y=5.
- Resolution in MODE 1:
  - Internal pointer ptr (W bits) holds the index of the last grant.
  - The search starts at (ptr+1) mod N, ascends, wraps past N-1 to 0, and the first set bit wins.
  - On every accepted non-zero vector, ptr is updated to y.
- Zero vector (in=0): y=0, zero=1, multi=0, and ptr is unchanged. The vector is still accepted and still produces an output beat.
- One-hot vector: both modes give an identical y equal to the set index, with multi=0.
- multi=1 iff popcount(in) ≥ 2. zero and multi are never both 1.
- en low:
  - No input is accepted.
  - A pending output beat remains presented and may still be popped.
  - ptr is frozen.
- In MODE 0, ptr exists but is ignored and its logic may be optimised away.

## Timing
- Latency: 1 cycle from input transfer to out_valid=1 with the corresponding y.
- Throughput: 1 vector per cycle when out_ready is held at 1.
- Simultaneous pop and push in the same cycle: the output register loads the new vector, out_valid stays 1, and there is no bubble.
- Backpressure (out_ready=0 while out_valid=1):
  - in_ready=0.
  - y, zero, multi and out_valid hold stable until popped.
- Reset (asserted asynchronously, at any time including mid-transfer):
  - out_valid=0, y=0, zero=0, multi=0.
  - ptr=N-1, so the first round-robin search starts at bit 0.
  - in_ready is 0 while rst is high and follows en after release.
- No state changes on the first clock edge while rst is still high. Release is synchronous to clk at the system level.

## Test plan
- Reset, MODE 0, N=8:
  - Stimulus: assert rst mid-stream, then release it; send in=8'h01, 8'h02 through 8'h80 with out_ready=1.
  - Required: outputs are 0 during reset; y=0..7 one cycle after each input, multi=0, zero=0, continuous out_valid.
- Priority and flags, MODE 0:
  - Stimulus: in=8'b1001_0100, then in=8'h00.
  - Required: first beat y=7, multi=1; second beat y=0, zero=1, multi=0.
- Round-robin, MODE 1:
  - Stimulus: from reset, in=8'b1000_1001 applied on 4 consecutive beats.
  - Required: y sequence 0,3,7,0; a following in=8'h00 leaves ptr unchanged, and the next in=8'b1000_1001 gives y=3.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0, y stable; then out_ready=1 drains one beat per cycle with no loss and no duplication.
- Enable and random check, N=16, both modes:
  - Stimulus: toggle en randomly against a reference model.
  - Required: no acceptance while en=0, ptr frozen, all y/zero/multi values match the model.
